// File: rtl/ctrl_seq_if.sv
// ---------------------------------------------------------------------------
// ctrl_seq_if -- bundle between the multi-cycle control sequencer and the
// datapath/instruction ROM/data memory it drives.
//
// Signals (seen from the sequencer, i.e. the master modport):
//   start       in   level request to (re)start the program at address 0
//   instr       in   instruction word addressed by pc (combinational ROM)
//   zero        in   ALU equality flag
//   lut_target  in   absolute branch target for the current beq
//   mem_ack     in   data-memory completion strobe
//   pc          out  instruction address
//   alu_cmd     out  ALU opcode (ir[8:6])
//   rd_addrA    out  register read pointer A / write address (ir[5:3])
//   rd_addrB    out  register read pointer B (ir[2:0])
//   reg_wr_en   out  one-cycle register write strobe
//   mem_req     out  data-memory request
//   mem_we      out  1 = store, 0 = load
//   done        out  program halted
// ---------------------------------------------------------------------------
interface ctrl_seq_if #(
    parameter int PC_W = 10
);
    logic            start;
    logic [8:0]      instr;
    logic            zero;
    logic [PC_W-1:0] lut_target;
    logic            mem_ack;

    logic [PC_W-1:0] pc;
    logic [2:0]      alu_cmd;
    logic [2:0]      rd_addrA;
    logic [2:0]      rd_addrB;
    logic            reg_wr_en;
    logic            mem_req;
    logic            mem_we;
    logic            done;

    // Sequencer side.
    modport master (
        input  start, instr, zero, lut_target, mem_ack,
        output pc, alu_cmd, rd_addrA, rd_addrB, reg_wr_en, mem_req, mem_we, done
    );

    // Datapath / memory / host side.
    modport slave (
        output start, instr, zero, lut_target, mem_ack,
        input  pc, alu_cmd, rd_addrA, rd_addrB, reg_wr_en, mem_req, mem_we, done
    );
endinterface

// File: rtl/ctrl_seq.sv
// ---------------------------------------------------------------------------
// ctrl_seq -- multi-cycle instruction sequencer.
//
// Walks a program held in an external ROM: FETCH latches the instruction,
// DECODE/EXEC present opcode and register pointers, loads/stores stall in MEM
// until the memory acknowledges, WB issues the register write strobe and
// advances pc (pc+1 or the branch target of a taken beq). The halt word parks
// the sequencer in HALT with done=1 until start is seen again.
//
// Ports:
//   clk    sole clock, rising edge
//   rst_n  asynchronous, active-low reset
//   bus    ctrl_seq_if.master (see interface header for the signal list)
//
// Every output is a flop: the next value of each strobe is chosen together
// with the next state, so the strobe is high exactly while the FSM sits in
// the state that owns it (reg_wr_en in WB, mem_req/mem_we in MEM, done in
// HALT).
// ---------------------------------------------------------------------------
module ctrl_seq #(
    parameter int         PC_W       = 10,
    parameter logic [8:0] HALT_INSTR = 9'h1FF
) (
    input  logic       clk,
    input  logic       rst_n,
    ctrl_seq_if.master bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        HALT   = 3'd6
    } state_t;

    localparam logic [2:0] OP_BEQ   = 3'b011;
    localparam logic [2:0] OP_LOAD  = 3'b101;
    localparam logic [2:0] OP_STORE = 3'b110;

    state_t          state_reg, state_next;
    logic [PC_W-1:0] pc_reg, pc_next;
    logic [8:0]      ir_reg, ir_next;
    logic            taken_reg, taken_next;
    logic            reg_wr_en_reg, reg_wr_en_next;
    logic            mem_req_reg, mem_req_next;
    logic            mem_we_reg, mem_we_next;
    logic            done_reg, done_next;

    logic [2:0]      opcode;

    assign opcode = ir_reg[8:6];

    // beq and store are the only opcodes that do not write a register.
    function automatic logic op_writes(input logic [2:0] op);
        return !((op == OP_BEQ) || (op == OP_STORE));
    endfunction

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            pc_reg        <= '0;
            ir_reg        <= '0;
            taken_reg     <= 1'b0;
            reg_wr_en_reg <= 1'b0;
            mem_req_reg   <= 1'b0;
            mem_we_reg    <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            pc_reg        <= pc_next;
            ir_reg        <= ir_next;
            taken_reg     <= taken_next;
            reg_wr_en_reg <= reg_wr_en_next;
            mem_req_reg   <= mem_req_next;
            mem_we_reg    <= mem_we_next;
            done_reg      <= done_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        pc_next        = pc_reg;
        ir_next        = ir_reg;
        taken_next     = taken_reg;
        done_next      = done_reg;
        // Strobes default low so they only live for the state that sets them.
        reg_wr_en_next = 1'b0;
        mem_req_next   = 1'b0;
        mem_we_next    = 1'b0;

        unique case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    state_next = FETCH;
                    pc_next    = '0;
                end
            end

            FETCH: begin
                ir_next    = bus.instr;
                taken_next = 1'b0;
                if (bus.instr == HALT_INSTR) begin
                    state_next = HALT;
                    done_next  = 1'b1;
                end else begin
                    state_next = DECODE;
                end
            end

            DECODE: begin
                state_next = EXEC;
            end

            EXEC: begin
                taken_next = (opcode == OP_BEQ) && bus.zero;
                if ((opcode == OP_LOAD) || (opcode == OP_STORE)) begin
                    state_next   = MEM;
                    mem_req_next = 1'b1;
                    mem_we_next  = (opcode == OP_STORE);
                end else begin
                    state_next     = WB;
                    reg_wr_en_next = op_writes(opcode);
                end
            end

            MEM: begin
                // Wait for the acknowledge for as long as it takes; the
                // request is held steady the whole time.
                if (bus.mem_ack) begin
                    state_next     = WB;
                    reg_wr_en_next = op_writes(opcode);
                end else begin
                    mem_req_next = 1'b1;
                    mem_we_next  = (opcode == OP_STORE);
                end
            end

            WB: begin
                state_next = FETCH;
                // Natural PC_W-bit overflow gives the all-ones -> 0 wrap.
                pc_next    = taken_reg ? bus.lut_target : pc_reg + 1'b1;
            end

            HALT: begin
                if (bus.start) begin
                    state_next = FETCH;
                    pc_next    = '0;
                    done_next  = 1'b0;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs (all straight from flops)
    // ------------------------------------------------------------------
    assign bus.pc        = pc_reg;
    assign bus.alu_cmd   = ir_reg[8:6];
    assign bus.rd_addrA  = ir_reg[5:3];
    assign bus.rd_addrB  = ir_reg[2:0];
    assign bus.reg_wr_en = reg_wr_en_reg;
    assign bus.mem_req   = mem_req_reg;
    assign bus.mem_we    = mem_we_reg;
    assign bus.done      = done_reg;

endmodule

// File: tb/tb_ctrl_seq.sv
// ---------------------------------------------------------------------------
// tb_ctrl_seq -- self-checking bench for ctrl_seq.
//
// The ROM, branch flag and branch target are tables indexed by pc. An
// instruction-level model tracks the expected pc and, for each instruction,
// derives the expected decode fields, write strobe, memory request length
// and next pc from the opcode rules; the bench then steps the clock through
// the instruction and compares the outputs every cycle. Inputs that must be
// ignored (start outside IDLE/HALT, mem_ack outside MEM) are randomised.
// ---------------------------------------------------------------------------
module tb_ctrl_seq;

    localparam int         PC_W   = 10;
    localparam logic [8:0] HALT_W = 9'h1FF;

    logic clk;
    logic rst_n;

    ctrl_seq_if #(.PC_W(PC_W)) bus ();

    ctrl_seq #(
        .PC_W      (PC_W),
        .HALT_INSTR(HALT_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    logic [8:0]      rom      [0:(1<<PC_W)-1];
    logic            zero_tab [0:(1<<PC_W)-1];
    logic [PC_W-1:0] lut_tab  [0:(1<<PC_W)-1];

    assign bus.instr      = rom[bus.pc];
    assign bus.zero       = zero_tab[bus.pc];
    assign bus.lut_target = lut_tab[bus.pc];

    int              checks = 0;
    int              errors = 0;
    logic [PC_W-1:0] exp_pc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Random values on inputs the sequencer must ignore in the coming cycle.
    task automatic noise();
        bus.start   = 1'($urandom_range(0, 1));
        bus.mem_ack = 1'($urandom_range(0, 1));
    endtask

    // Runs one instruction starting with the DUT in FETCH at exp_pc and
    // leaves it in FETCH of the next instruction. n_mem = MEM stall cycles.
    task automatic exec_one(input int n_mem);
        logic [8:0]      iw;
        logic [2:0]      op;
        logic            wr;
        logic            tk;
        logic [PC_W-1:0] nxt;
        int              k;
        iw = rom[exp_pc];
        op = iw[8:6];
        chk("fetch_pc",   32'(bus.pc),        32'(exp_pc));
        chk("fetch_wr",   32'(bus.reg_wr_en), 32'(0));
        chk("fetch_req",  32'(bus.mem_req),   32'(0));
        chk("fetch_done", 32'(bus.done),      32'(0));
        if (iw == HALT_W) begin
            bus.start   = 1'b0;
            bus.mem_ack = 1'($urandom_range(0, 1));
            step();
            chk("halt_done", 32'(bus.done), 32'(1));
            chk("halt_pc",   32'(bus.pc),   32'(exp_pc));
            k = int'($urandom_range(0, 2));
            for (int i = 0; i < k; i++) begin
                step();
                chk("halt_hold_done", 32'(bus.done), 32'(1));
                chk("halt_hold_pc",   32'(bus.pc),   32'(exp_pc));
            end
            bus.start = 1'b1;
            step();
            bus.start = 1'b0;
            chk("restart_pc",   32'(bus.pc),   32'(0));
            chk("restart_done", 32'(bus.done), 32'(0));
            $display("instr pc=%03h HALT held=%0d -> restart", exp_pc, k);
            exp_pc = '0;
            return;
        end
        wr  = !(op == 3'b011 || op == 3'b110);
        tk  = (op == 3'b011) && zero_tab[exp_pc];
        nxt = tk ? lut_tab[exp_pc] : exp_pc + 1'b1;

        noise();
        step();                                   // DECODE
        chk("dec_alu", 32'(bus.alu_cmd),   32'(op));
        chk("dec_rsa", 32'(bus.rd_addrA),  32'(iw[5:3]));
        chk("dec_rsb", 32'(bus.rd_addrB),  32'(iw[2:0]));
        chk("dec_wr",  32'(bus.reg_wr_en), 32'(0));
        chk("dec_req", 32'(bus.mem_req),   32'(0));
        noise();
        step();                                   // EXEC
        chk("exe_alu", 32'(bus.alu_cmd),   32'(op));
        chk("exe_wr",  32'(bus.reg_wr_en), 32'(0));
        chk("exe_req", 32'(bus.mem_req),   32'(0));
        noise();
        step();
        if (op == 3'b101 || op == 3'b110) begin
            for (int i = 0; i < n_mem; i++) begin // MEM
                chk("mem_req", 32'(bus.mem_req),   32'(1));
                chk("mem_we",  32'(bus.mem_we),    32'(op == 3'b110));
                chk("mem_wr",  32'(bus.reg_wr_en), 32'(0));
                bus.start   = 1'($urandom_range(0, 1));
                bus.mem_ack = (i == n_mem - 1);
                step();
            end
            bus.mem_ack = 1'b0;
        end
        chk("wb_wr",  32'(bus.reg_wr_en), 32'(wr));   // WB
        chk("wb_req", 32'(bus.mem_req),   32'(0));
        chk("wb_alu", 32'(bus.alu_cmd),   32'(op));
        noise();
        step();
        $display("instr pc=%03h iw=%03h op=%0d wr=%0d taken=%0d next=%03h",
                 exp_pc, iw, op, wr, tk, nxt);
        exp_pc = nxt;
    endtask

    initial begin
        for (int i = 0; i < (1 << PC_W); i++) begin
            rom[i]      = 9'b000_000_000;
            zero_tab[i] = 1'b0;
            lut_tab[i]  = '0;
        end
        rom[0]          = 9'b000_001_010;           // add
        rom[1]          = 9'b011_011_100;           // beq taken -> 0x040
        zero_tab[1]     = 1'b1;
        lut_tab[1]      = 10'h040;
        rom[2]          = HALT_W;
        rom[10'h040]    = 9'b011_011_100;           // beq not taken
        rom[10'h041]    = 9'b101_010_011;           // load
        rom[10'h042]    = 9'b110_001_111;           // store
        rom[10'h043]    = 9'b011_000_000;           // beq -> 0x3FF
        zero_tab[10'h043] = 1'b1;
        lut_tab[10'h043]  = 10'h3FF;
        rom[10'h3FF]    = 9'b000_111_001;           // add at top, wraps

        bus.start   = 1'b0;
        bus.mem_ack = 1'b0;
        rst_n       = 1'b1;
        #2 rst_n    = 1'b0;
        #1;
        chk("rst_pc",   32'(bus.pc),        32'(0));
        chk("rst_done", 32'(bus.done),      32'(0));
        chk("rst_wr",   32'(bus.reg_wr_en), 32'(0));
        chk("rst_req",  32'(bus.mem_req),   32'(0));
        chk("rst_we",   32'(bus.mem_we),    32'(0));
        chk("rst_alu",  32'(bus.alu_cmd),   32'(0));
        chk("rst_rsa",  32'(bus.rd_addrA),  32'(0));
        chk("rst_rsb",  32'(bus.rd_addrB),  32'(0));
        $display("reset applied");
        step();
        step();
        rst_n       = 1'b1;
        bus.mem_ack = 1'b1;                         // ignored in IDLE
        step();
        step();
        chk("idle_pc",  32'(bus.pc),        32'(0));
        chk("idle_wr",  32'(bus.reg_wr_en), 32'(0));
        chk("idle_req", 32'(bus.mem_req),   32'(0));
        bus.mem_ack = 1'b0;
        bus.start   = 1'b1;
        step();
        bus.start   = 1'b0;
        exp_pc      = '0;

        // Directed program walk.
        exec_one(1);            // add @0
        exec_one(1);            // beq taken @1 -> 0x040
        exec_one(1);            // beq not taken @0x040
        exec_one(3);            // load, 3 stall cycles
        exec_one(1);            // store, 1 stall cycle
        exec_one(1);            // beq -> 0x3FF
        exec_one(1);            // add @0x3FF wraps to 0
        zero_tab[1] = 1'b0;
        exec_one(1);            // add @0
        exec_one(1);            // beq not taken -> 2
        exec_one(1);            // HALT @2, restart

        // Reset in the middle of a memory stall.
        rom[0] = 9'b101_000_001;
        bus.mem_ack = 1'b0;
        step();
        step();
        step();
        chk("mid_req", 32'(bus.mem_req), 32'(1));
        step();
        step();
        chk("mid_req_hold", 32'(bus.mem_req), 32'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_req",  32'(bus.mem_req),   32'(0));
        chk("mid_rst_pc",   32'(bus.pc),        32'(0));
        chk("mid_rst_done", 32'(bus.done),      32'(0));
        chk("mid_rst_wr",   32'(bus.reg_wr_en), 32'(0));
        $display("reset during MEM stall");
        step();
        rst_n       = 1'b1;
        bus.mem_ack = 1'b1;
        step();
        chk("post_rst_wr",  32'(bus.reg_wr_en), 32'(0));
        chk("post_rst_req", 32'(bus.mem_req),   32'(0));
        step();
        chk("post_rst_wr2", 32'(bus.reg_wr_en), 32'(0));
        bus.mem_ack = 1'b0;

        // Random program.
        for (int i = 0; i < (1 << PC_W); i++) begin
            rom[i]      = 9'($urandom_range(0, 511));
            zero_tab[i] = 1'($urandom_range(0, 1));
            lut_tab[i]  = PC_W'($urandom_range(0, (1 << PC_W) - 1));
        end
        rom[10'($urandom_range(0, 1023))] = HALT_W;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        exp_pc    = '0;
        for (int n = 0; n < 150; n++) begin
            exec_one(int'($urandom_range(1, 4)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ctrl_seq.md
CTRL_SEQ -- requirements
Module: ctrl_seq

Interface
REQ-001 Parameter PC_W, default 10, program counter width in bits.
REQ-002 Parameter HALT_INSTR, default 9'h1FF, instruction word that stops execution.
REQ-003 clk  input  1  sole clock, all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 start  input  1  level request to begin or restart a program from address 0.
REQ-006 instr  input  9  instruction word addressed by pc, combinational from instruction ROM; [8:6] opcode, [5:3] rs, [2:0] rt.
REQ-007 zero  input  1  ALU equality flag.
REQ-008 lut_target  input  PC_W  absolute branch target for the current beq.
REQ-009 mem_ack  input  1  data-memory completion strobe.
REQ-010 pc  output  PC_W  instruction address.
REQ-011 alu_cmd  output  3  ALU opcode, equal to ir[8:6].
REQ-012 rd_addrA / rd_addrB  output  3 each  register read pointers, equal to ir[5:3] / ir[2:0].
REQ-013 reg_wr_en  output  1  one-cycle register write strobe, write address rd_addrA.
REQ-014 mem_req / mem_we  output  1 each  memory request; mem_we=1 store, 0 load.
REQ-015 done  output  1  program halted.

Function
REQ-016 States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT; state and outputs registered.
REQ-017 IDLE: start=1 -> FETCH with pc<=0; else stay.
REQ-018 FETCH: ir<=instr; instr==HALT_INSTR -> HALT, else DECODE; one cycle.
REQ-019 DECODE -> EXEC unconditionally; alu_cmd/rd_addrA/rd_addrB driven from ir from DECODE through WB.
REQ-020 EXEC: taken<=(ir[8:6]==3'b011)&&zero; opcode 101 (load) or 110 (store) -> MEM, others -> WB.
REQ-021 MEM: mem_req=1, mem_we=(opcode==110), held steady until mem_ack=1 sampled, then WB; no timeout, waits indefinitely.
REQ-022 mem_ack outside MEM is ignored.
REQ-023 WB: reg_wr_en=1 for exactly this cycle for opcodes 000,001,010,100,101,111; 0 for 011 and 110.
REQ-024 WB: pc<=taken ? lut_target : pc+1, modulo 2^PC_W (pc all-ones wraps to 0); next state FETCH.
REQ-025 Instruction latency: 4 cycles non-memory (FETCH..WB), 4+N cycles memory where N>=1 is MEM cycles.
REQ-026 HALT: done=1, pc frozen; start=1 -> FETCH with pc<=0, done<=0; start held high continuously after halt restarts immediately.
REQ-027 start ignored in all states except IDLE and HALT.
REQ-028 taken cleared at each FETCH; branch to lut_target==pc (self-loop) is legal.

Reset
REQ-029 rst_n=0 asynchronously forces state=IDLE, pc=0, ir=0, taken=0, reg_wr_en=0, mem_req=0, mem_we=0, done=0, alu_cmd=0, rd_addrA=rd_addrB=0.
REQ-030 Reset mid-MEM drops mem_req the same instant; no write strobe issued after release; first edge after release evaluates IDLE.

Verification
REQ-031 Reset release, start=1, ROM[0]=9'b000_001_010 (add) -> FETCH,DECODE,EXEC,WB; alu_cmd=000, rd_addrA=1, rd_addrB=2; reg_wr_en high exactly one cycle in WB; pc=1 at next FETCH.
REQ-032 beq 9'b011_011_100, zero=1, lut_target=10'h040 -> pc=0x040, reg_wr_en stays 0; repeat with zero=0 -> pc=old pc+1.
REQ-033 Load 9'b101_010_011, mem_ack delayed 3 cycles -> mem_req=1, mem_we=0 for 3 cycles, then WB with reg_wr_en=1; store 9'b110_.. -> mem_we=1, reg_wr_en=0.
REQ-034 Place add at pc=0x3FF -> pc wraps to 0x000 after WB.
REQ-035 ROM[2]=9'h1FF -> done=1 in HALT, pc=2 frozen; pulse start -> pc=0, done=0, FETCH next cycle.
REQ-036 Assert rst_n=0 during MEM stall -> mem_req=0 immediately, state IDLE, done=0, pc=0.
